// File: rtl/fifo_rd_packer_if.sv
// Read-side bundle between the FIFO, the packer and the downstream beat consumer.
// Latency: none, wires only. Backpressure: out_valid/out_ready on the beat side, fifo_empty on the pop side.
// master = packer side, slave = FIFO/consumer side.
interface fifo_rd_packer_if #(
   parameter int DATA_WIDTH = 8,
   parameter int PACK       = 4,
   parameter int CNT_WIDTH  = 16
);
   logic                       fifo_empty;
   logic                       fifo_rd_en;
   logic [DATA_WIDTH-1:0]      fifo_data;
   logic                       flush;
   logic                       flush_done;
   logic                       out_valid;
   logic                       out_ready;
   logic [DATA_WIDTH*PACK-1:0] out_data;
   logic [PACK-1:0]            out_keep;
   logic                       out_last;
   logic [CNT_WIDTH-1:0]       word_cnt;

   modport master (
      input  fifo_empty, fifo_data, flush, out_ready,
      output fifo_rd_en, flush_done, out_valid, out_data, out_keep, out_last, word_cnt
   );

   modport slave (
      output fifo_empty, fifo_data, flush, out_ready,
      input  fifo_rd_en, flush_done, out_valid, out_data, out_keep, out_last, word_cnt
   );
endinterface

// File: rtl/fifo_rd_packer.sv
// Pops FIFO words (registered read) and packs PACK of them per beat; flush emits the partial beat with keep/last.
// Latency: beat valid PACK+1 edges after the first pop. Backpressure: a held beat plus a full assembly register stop pops.
// Define FIFO_RD_MSB_FIRST_EN to place the first popped word in the top slot.
module fifo_rd_packer #(
   parameter int DATA_WIDTH = 8,
   parameter int PACK       = 4,
   parameter int CNT_WIDTH  = 16
) (
   input logic              rd_clk,
   input logic              rst_n,
   fifo_rd_packer_if.master pk_if
);

   localparam int BW = DATA_WIDTH * PACK;
   localparam int FW = $clog2(PACK + 1);
   localparam logic [FW-1:0] FULL = FW'(PACK);
`ifdef FIFO_RD_MSB_FIRST_EN
   localparam bit MSB_FIRST = 1'b1;
`else
   localparam bit MSB_FIRST = 1'b0;
`endif

   typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, EMIT = 2'd2} state_t;

   state_t               state_q, state_d;
   logic                 en_q;
   logic [FW-1:0]        fill_q, fill_d;
   logic                 pend_q;
   logic [BW-1:0]        asm_q, asm_d;
   logic [BW-1:0]        out_data_q, out_data_d;
   logic [PACK-1:0]      out_keep_q, out_keep_d;
   logic                 out_valid_q, out_valid_d;
   logic                 out_last_q, out_last_d;
   logic [CNT_WIDTH-1:0] word_cnt_q, word_cnt_d;

   logic            rd_en;
   logic            flush_done;
   logic            slot_free;
   logic            handoff;
   logic            drain_ok;
   logic            emit_go;
   logic [PACK-1:0] part_keep;

   function automatic int slot_of(input int i);
      return MSB_FIRST ? (PACK - 1 - i) : i;
   endfunction

   assign slot_free = !out_valid_q || pk_if.out_ready;
   assign handoff   = (fill_q == FULL) && slot_free;
   assign drain_ok  = !pend_q && (fill_q != FULL);
   assign emit_go   = (state_q == EMIT) && slot_free;

   always_ff @(posedge rd_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (pk_if.flush) state_d = DRAIN;
         DRAIN:   if (drain_ok) state_d = (fill_q == '0) ? RUN : EMIT;
         EMIT:    if (slot_free) state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   // en_q keeps pops off while reset is asserted and for the first edge after release
   always_comb begin
      rd_en      = 1'b0;
      flush_done = 1'b0;
      case (state_q)
         RUN:     rd_en = en_q && !pk_if.fifo_empty && ((int'(fill_q) + int'(pend_q)) < PACK);
         DRAIN:   flush_done = drain_ok && (fill_q == '0);
         EMIT:    flush_done = slot_free;
         default: ;
      endcase
   end

   always_comb begin
      part_keep = '0;
      for (int i = 0; i < PACK; i++) begin
         part_keep[slot_of(i)] = (i < int'(fill_q));
      end
   end

   // Assembly slots beyond fill stay zero because asm is cleared on every unload
   always_comb begin
      fill_d      = fill_q;
      asm_d       = asm_q;
      word_cnt_d  = word_cnt_q;
      out_valid_d = out_valid_q && !pk_if.out_ready;
      out_data_d  = out_data_q;
      out_keep_d  = out_keep_q;
      out_last_d  = out_last_q;
      if (pend_q) begin
         for (int i = 0; i < PACK; i++) begin
            if (fill_q == FW'(i)) asm_d[slot_of(i)*DATA_WIDTH +: DATA_WIDTH] = pk_if.fifo_data;
         end
         fill_d     = fill_q + 1'b1;
         word_cnt_d = word_cnt_q + 1'b1;
      end
      if (handoff || emit_go) begin
         out_valid_d = 1'b1;
         out_data_d  = asm_q;
         out_keep_d  = handoff ? '1 : part_keep;
         out_last_d  = !handoff;
         fill_d      = '0;
         asm_d       = '0;
      end
   end

   always_ff @(posedge rd_clk or negedge rst_n) begin
      if (!rst_n) begin
         en_q        <= 1'b0;
         fill_q      <= '0;
         pend_q      <= 1'b0;
         asm_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_keep_q  <= '0;
         out_last_q  <= 1'b0;
         word_cnt_q  <= '0;
      end else begin
         en_q        <= 1'b1;
         fill_q      <= fill_d;
         pend_q      <= rd_en;
         asm_q       <= asm_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_keep_q  <= out_keep_d;
         out_last_q  <= out_last_d;
         word_cnt_q  <= word_cnt_d;
      end
   end

   assign pk_if.fifo_rd_en = rd_en;
   assign pk_if.flush_done = flush_done;
   assign pk_if.out_valid  = out_valid_q;
   assign pk_if.out_data   = out_data_q;
   assign pk_if.out_keep   = out_keep_q;
   assign pk_if.out_last   = out_last_q;
   assign pk_if.word_cnt   = word_cnt_q;

   a_fill_bound: assert property (@(posedge rd_clk) disable iff (!rst_n) fill_q <= FULL);
   a_no_pop_empty: assert property (@(posedge rd_clk) disable iff (!rst_n) !(rd_en && pk_if.fifo_empty));
   a_no_capture_full: assert property (@(posedge rd_clk) disable iff (!rst_n) !(pend_q && fill_q == FULL));

endmodule
